// File: rtl/msg_page_sequencer.sv
// Page sequencer for the six-digit message bank: dwell-timed auto-advance, next/prev/pause
// buttons, and time-multiplexed scanning of the bank digits onto one seven-segment decoder.
module msg_page_sequencer #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int SCAN_CYCLES  = 50000,
  parameter int NUM_PAGES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_pause,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  output logic [2:0] p,
  output logic [5:0] digit_sel,
  output logic [3:0] digit_val,
  output logic       blank,
  output logic       page_tick,
  output logic       paused
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_ONE   = SW'(1);
  localparam logic [2:0]    PAGE_LAST  = 3'(NUM_PAGES - 1);

  typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [SW-1:0] scan;
  logic [2:0]    scan_idx;
  // Button vectors are ordered {pause, prev, next}.
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    last;
  logic [2:0]    armed;
  logic [1:0]    warm;
  logic [2:0]    rise;
  logic          step_next;
  logic          step_prev;
  logic          expire;
  logic [2:0]    page_inc;
  logic [2:0]    page_dec;
  logic          scan_wrap;
  logic [2:0]    next_idx;
  logic [3:0]    next_val;

  // Synchronizer and edge detect; a button only arms after a real low sample, so a
  // level held through reset release never counts as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      last  <= 3'b000;
      armed <= 3'b000;
      warm  <= 2'b00;
    end else begin
      sync1 <= {btn_pause, btn_prev, btn_next};
      sync2 <= sync1;
      last  <= sync2;
      warm  <= {warm[0], 1'b1};
      armed <= armed | ({3{warm[1]}} & ~sync2);
    end
  end

  assign rise = sync2 & ~last & armed;

  // Page event decode with wrap at NUM_PAGES rather than at the 3-bit limit.
  always_comb begin
    step_next = rise[0] & ~rise[1];
    step_prev = rise[1] & ~rise[0];
    expire    = (state == RUN) && (dwell == DWELL_LAST);
    if (p == PAGE_LAST) begin
      page_inc = 3'd0;
    end else begin
      page_inc = p + 3'd1;
    end
    if (p == 3'd0) begin
      page_dec = PAGE_LAST;
    end else begin
      page_dec = p - 3'd1;
    end
  end

  // Run/pause FSM with page register, dwell timer and registered tick/paused outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      paused    <= 1'b0;
      p         <= 3'd0;
      dwell     <= '0;
      page_tick <= 1'b0;
    end else begin
      // prev outranks a coinciding dwell expiry; next and expiry merge into one step
      if (step_prev) begin
        p         <= page_dec;
        page_tick <= 1'b1;
      end else if (step_next || expire) begin
        p         <= page_inc;
        page_tick <= 1'b1;
      end else begin
        p         <= p;
        page_tick <= 1'b0;
      end

      if (step_prev || step_next || expire || rise[2]) begin
        dwell <= '0;
      end else if (state == RUN) begin
        dwell <= dwell + DWELL_ONE;
      end else begin
        dwell <= dwell;
      end

      case (state)
        RUN: begin
          if (rise[2]) begin
            state  <= PAUSE;
            paused <= 1'b1;
          end else begin
            state  <= RUN;
            paused <= 1'b0;
          end
        end
        PAUSE: begin
          if (rise[2]) begin
            state  <= RUN;
            paused <= 1'b0;
          end else begin
            state  <= PAUSE;
            paused <= 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          paused <= 1'b0;
        end
      endcase
    end
  end

  // Next scan position and the bank digit it selects.
  always_comb begin
    scan_wrap = (scan == SCAN_LAST);
    if (scan_wrap) begin
      next_idx = (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      next_idx = scan_idx;
    end
    case (next_idx)
      3'd0:    next_val = d0;
      3'd1:    next_val = d1;
      3'd2:    next_val = d2;
      3'd3:    next_val = d3;
      3'd4:    next_val = d4;
      3'd5:    next_val = d5;
      default: next_val = d0;
    endcase
  end

  // Digit scanner; value, enable and blank are registered together from next_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan      <= '0;
      scan_idx  <= 3'd0;
      digit_sel <= 6'b000001;
      digit_val <= 4'd8;
      blank     <= 1'b0;
    end else begin
      scan      <= scan_wrap ? '0 : scan + SCAN_ONE;
      scan_idx  <= next_idx;
      digit_sel <= 6'b000001 << next_idx;
      digit_val <= next_val;
      blank     <= (next_val >= 4'd10);
    end
  end

endmodule

// File: tb/tb_msg_page_sequencer.sv
// Bench for msg_page_sequencer: an 8-page instance checked against a page/scan model,
// and a 5-page instance checked with directed expectations.
module tb_msg_page_sequencer;

  localparam int DWELL = 10;
  localparam int SCAN  = 4;
  localparam int NP    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, btn_next, btn_prev, btn_pause;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic [2:0] p;
  logic [5:0] digit_sel;
  logic [3:0] digit_val;
  logic       blank, page_tick, paused;

  logic       reset5, next5, prev5, pause5;
  logic [2:0] p5;
  logic [5:0] sel5;
  logic [3:0] val5;
  logic       blank5, tick5, paused5;

  int errors = 0;
  int checks = 0;

  msg_page_sequencer #(.DWELL_CYCLES(DWELL), .SCAN_CYCLES(SCAN), .NUM_PAGES(NP)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .btn_pause(btn_pause),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .p(p), .digit_sel(digit_sel), .digit_val(digit_val), .blank(blank),
    .page_tick(page_tick), .paused(paused));

  msg_page_sequencer #(.DWELL_CYCLES(DWELL), .SCAN_CYCLES(SCAN), .NUM_PAGES(5)) dut5 (
    .clk(clk), .reset(reset5), .btn_next(next5), .btn_prev(prev5), .btn_pause(pause5),
    .d0(4'd1), .d1(4'd2), .d2(4'd3), .d3(4'd4), .d4(4'd5), .d5(4'd11),
    .p(p5), .digit_sel(sel5), .digit_val(val5), .blank(blank5),
    .page_tick(tick5), .paused(paused5));

  // Bank model: latches the page on the falling edge, digit 5 is always blank.
  logic [3:0] bank_mem [8][6];
  logic [2:0] bank_page;
  always @(negedge clk or posedge reset) begin
    if (reset) bank_page <= 3'd0;
    else       bank_page <= p;
  end
  assign d0 = bank_mem[bank_page][0];
  assign d1 = bank_mem[bank_page][1];
  assign d2 = bank_mem[bank_page][2];
  assign d3 = bank_mem[bank_page][3];
  assign d4 = bank_mem[bank_page][4];
  assign d5 = bank_mem[bank_page][5];

  // Reference model state.
  int         m_page, m_cnt, m_cyc;
  logic       m_run, m_tick, m_blank;
  logic [2:0] hn, hp, hpa;
  logic [5:0] m_sel;
  logic [3:0] m_val;

  task automatic model_reset;
    m_page = 0; m_cnt = 0; m_cyc = 0; m_run = 1'b1; m_tick = 1'b0;
    hn = 3'b111; hp = 3'b111; hpa = 3'b111;
    m_sel = 6'b000001; m_val = 4'd8; m_blank = 1'b0;
  endtask

  // A press sampled at edge m-2 after a low sample at m-3 acts at edge m.
  task automatic model_edge(input logic n, input logic pr, input logic pa);
    logic rn, rp, rpa, expire;
    logic [5:0] one_hot;
    int idx;
    rn  = hn[1] & ~hn[2];
    rp  = hp[1] & ~hp[2];
    rpa = hpa[1] & ~hpa[2];
    hn  = {hn[1:0], n};
    hp  = {hp[1:0], pr};
    hpa = {hpa[1:0], pa};
    m_cyc++;
    idx = (m_cyc / SCAN) % 6;
    one_hot = 6'b000001;
    m_sel = one_hot << idx;
    m_val = bank_mem[m_page][idx];
    m_blank = (m_val >= 4'd10);
    expire = m_run && (m_cnt == DWELL - 1);
    m_tick = 1'b0;
    if (rp && !rn) begin
      m_page = (m_page + NP - 1) % NP; m_tick = 1'b1;
    end else if ((rn && !rp) || expire) begin
      m_page = (m_page + 1) % NP; m_tick = 1'b1;
    end
    if (m_tick || rpa) m_cnt = 0;
    else if (m_run) m_cnt++;
    if (rpa) m_run = ~m_run;
  endtask

  task automatic step(input logic n, input logic pr, input logic pa);
    btn_next = n; btn_prev = pr; btn_pause = pa;
    @(posedge clk);
    model_edge(n, pr, pa);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    checks++;
    if (p !== 3'd0 || digit_sel !== 6'b000001 || digit_val !== 4'd8 || blank !== 1'b0 ||
        page_tick !== 1'b0 || paused !== 1'b0)
      begin errors++; $display("FAIL reset p=%0d sel=%b val=%0d blank=%b tick=%b paused=%b, want 0 000001 8 0 0 0",
                               p, digit_sel, digit_val, blank, page_tick, paused); end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (p !== 3'd0 || digit_val !== 4'd8)
      begin errors++; $display("FAIL reset_held p=%0d val=%0d, want 0 8", p, digit_val); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_auto;
    int ticks = 0;
    for (int i = 1; i <= 80; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (page_tick === 1'b1) ticks++;
      checks++;
      if (p !== 3'(m_page) || page_tick !== m_tick)
        begin errors++; $display("FAIL auto cyc=%0d p=%0d tick=%b, want p=%0d tick=%b", i, p, page_tick, m_page, m_tick); end
    end
    checks++;
    if (ticks !== 8) begin errors++; $display("FAIL auto_ticks got %0d, want 8", ticks); end
    checks++;
    if (p !== 3'd0) begin errors++; $display("FAIL auto_wrap p=%0d, want 0", p); end
  endtask

  task automatic test_prev;
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'd7 || page_tick !== 1'b1)
      begin errors++; $display("FAIL prev_wrap p=%0d tick=%b, want 7 1", p, page_tick); end
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'd7) begin errors++; $display("FAIL prev_dwell p=%0d, want 7", p); end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'd0 || page_tick !== 1'b1)
      begin errors++; $display("FAIL prev_readvance p=%0d tick=%b, want 0 1", p, page_tick); end
  endtask

  task automatic test_pause;
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (paused !== 1'b1) begin errors++; $display("FAIL pause_on paused=%b, want 1", paused); end
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (p !== 3'd0 || page_tick !== 1'b0)
        begin errors++; $display("FAIL pause_frozen cyc=%0d p=%0d tick=%b, want 0 0", i, p, page_tick); end
    end
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'd1 || page_tick !== 1'b1 || paused !== 1'b1)
      begin errors++; $display("FAIL pause_next p=%0d tick=%b paused=%b, want 1 1 1", p, page_tick, paused); end
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (paused !== 1'b0) begin errors++; $display("FAIL pause_off paused=%b, want 0", paused); end
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'd1) begin errors++; $display("FAIL resume_dwell p=%0d, want 1", p); end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'd2 || page_tick !== 1'b1)
      begin errors++; $display("FAIL resume_advance p=%0d tick=%b, want 2 1", p, page_tick); end
  endtask

  task automatic run_to_cnt7;
    for (int k = 0; k < 2 * DWELL && m_cnt != DWELL - 3; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simul;
    int q;
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'd2 || page_tick !== 1'b0)
      begin errors++; $display("FAIL next_and_prev p=%0d tick=%b, want 2 0", p, page_tick); end
    run_to_cnt7();
    q = m_page;
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'((q + 1) % NP) || page_tick !== 1'b1)
      begin errors++; $display("FAIL next_on_expiry p=%0d tick=%b, want %0d 1", p, page_tick, (q + 1) % NP); end
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'((q + 1) % NP)) begin errors++; $display("FAIL next_on_expiry_single p=%0d, want %0d", p, (q + 1) % NP); end
    run_to_cnt7();
    q = m_page;
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'((q + NP - 1) % NP) || page_tick !== 1'b1)
      begin errors++; $display("FAIL prev_on_expiry p=%0d tick=%b, want %0d 1", p, page_tick, (q + NP - 1) % NP); end
    run_to_cnt7();
    q = m_page;
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p !== 3'((q + 1) % NP) || paused !== 1'b1)
      begin errors++; $display("FAIL pause_on_expiry p=%0d paused=%b, want %0d 1", p, paused, (q + 1) % NP); end
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    checks++;
    if (paused !== 1'b0) begin errors++; $display("FAIL unpause paused=%b, want 0", paused); end
  endtask

  task automatic test_scan;
    for (int i = 0; i < 48; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (digit_sel !== m_sel || digit_val !== m_val || blank !== m_blank)
        begin errors++; $display("FAIL scan cyc=%0d sel=%b val=%0d blank=%b, want %b %0d %b",
                                 i, digit_sel, digit_val, blank, m_sel, m_val, m_blank); end
      if (m_sel == 6'b100000) begin
        checks++;
        if (digit_val !== 4'd10 || blank !== 1'b1)
          begin errors++; $display("FAIL scan_blank val=%0d blank=%b, want 10 1", digit_val, blank); end
      end
    end
  endtask

  task automatic test_random;
    logic ln, lp, lpa;
    ln = 1'b0; lp = 1'b0; lpa = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ln = ~ln;
      if ($urandom_range(0, 7) == 0) lp = ~lp;
      if ($urandom_range(0, 11) == 0) lpa = ~lpa;
      step(ln, lp, lpa);
      checks++;
      if (p !== 3'(m_page) || page_tick !== m_tick || paused !== ~m_run)
        begin errors++; $display("FAIL random_page cyc=%0d p=%0d tick=%b paused=%b, want %0d %b %b",
                                 i, p, page_tick, paused, m_page, m_tick, ~m_run); end
      checks++;
      if (digit_sel !== m_sel || digit_val !== m_val || blank !== m_blank)
        begin errors++; $display("FAIL random_scan cyc=%0d sel=%b val=%0d blank=%b, want %b %0d %b",
                                 i, digit_sel, digit_val, blank, m_sel, m_val, m_blank); end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pages5;
    @(negedge clk);
    reset5 = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk); #1;
      checks++;
      if (p5 !== 3'((e / 10) % 5))
        begin errors++; $display("FAIL pages5 edge=%0d p=%0d, want %0d", e, p5, (e / 10) % 5); end
    end
    prev5 = 1'b1;
    @(posedge clk); #1;
    prev5 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (p5 !== 3'd4 || tick5 !== 1'b1)
      begin errors++; $display("FAIL pages5_prev p=%0d tick=%b, want 4 1", p5, tick5); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #3;
    next5 = 1'b1;
    reset5 = 1'b1;
    #1;
    checks++;
    if (p5 !== 3'd0 || val5 !== 4'd8 || sel5 !== 6'b000001 || tick5 !== 1'b0)
      begin errors++; $display("FAIL reset_mid p=%0d val=%0d sel=%b tick=%b, want 0 8 000001 0", p5, val5, sel5, tick5); end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset5 = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      checks++;
      if (p5 !== 3'd0) begin errors++; $display("FAIL held_next edge=%0d p=%0d, want 0", e, p5); end
    end
    @(posedge clk); #1;
    checks++;
    if (p5 !== 3'd1) begin errors++; $display("FAIL held_next_auto p=%0d, want 1", p5); end
    next5 = 1'b0;
  endtask

  initial begin
    btn_next = 1'b0; btn_prev = 1'b0; btn_pause = 1'b0;
    reset5 = 1'b1; next5 = 1'b0; prev5 = 1'b0; pause5 = 1'b0;
    for (int pg = 0; pg < 8; pg++)
      for (int di = 0; di < 6; di++)
        bank_mem[pg][di] = (di == 5) ? 4'd10 : 4'($urandom_range(0, 15));
    model_reset();
    test_reset();
    test_auto();
    test_prev();
    test_pause();
    test_simul();
    test_scan();
    test_random();
    test_pages5();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
